// File: rtl/mem_responder_pkg.sv
// Shared types and line geometry for the backing-store responder.
// Line width constants are common with the cache above it.
package mem_responder_pkg;

  localparam int MEM_ADDRW     = 32;
  localparam int MEM_WORDW     = 32;
  localparam int MEM_LINEITEMS = 16;
  localparam int MEM_LINEW     = MEM_WORDW * MEM_LINEITEMS;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND,
    WAIT_DROP
  } memstate_t;

  function automatic int line_offw(input int linew);
    return $clog2(linew / 8);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Line-wide request/valid bus between a cache level and its backing store.
// master = requester (cache), slave = responder.
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int ADDRW = MEM_ADDRW,
  parameter int LINEW = MEM_LINEW
);

  logic             request;
  logic             we;
  logic [ADDRW-1:0] addr;
  logic [LINEW-1:0] wdata;
  logic             valid;
  logic [LINEW-1:0] rdata;
  logic             busy;

  modport master (
    output request, we, addr, wdata,
    input  valid, rdata, busy
  );

  modport slave (
    input  request, we, addr, wdata,
    output valid, rdata, busy
  );

endinterface

// File: rtl/mem_line_array.sv
// DEPTH x LINEW line storage: one sync write port, one sync read port.
// Read register holds its value until the next read; storage is not reset.
module mem_line_array #(
  parameter int LINEW = 512,
  parameter int DEPTH = 1024,
  localparam int IDXW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [IDXW-1:0]  widx,
  input  logic [LINEW-1:0] wdata,
  input  logic             re,
  input  logic [IDXW-1:0]  ridx,
  output logic [LINEW-1:0] rdata
);

  logic [LINEW-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[widx] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[ridx];
  end

endmodule

// File: rtl/mem_responder.sv
// Backing-store responder with fixed access latency, one access at a time.
// Optional MEM_STATS_EN adds saturating rd_count / wr_count outputs.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDRW     = MEM_ADDRW,
  parameter int WORDW     = MEM_WORDW,
  parameter int LINEITEMS = MEM_LINEITEMS,
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 4
) (
  input  logic           clock,
  input  logic           reset,
  mem_responder_if.slave bus
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]    rd_count,
  output logic [31:0]    wr_count
`endif
);

  localparam int LINEW = WORDW * LINEITEMS;
  localparam int IDXW  = $clog2(DEPTH);
  localparam int OFFW  = line_offw(LINEW);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("mem_responder: LATENCY must be 1..255");
  end
  if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mem_responder: DEPTH must be a power of 2");
  end

  memstate_t        state_q, state_d;
  logic [7:0]       cnt_q;
  logic [IDXW-1:0]  idx_q;
  logic             we_q;
  logic [LINEW-1:0] wdata_q;
  logic             fire;
  logic             arr_we;
  logic             arr_re;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.request) begin
        idx_q   <= bus.addr[OFFW +: IDXW];
        we_q    <= bus.we;
        wdata_q <= bus.wdata;
        cnt_q   <= 8'(LATENCY - 1);
      end else if (state_q == BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (bus.request) state_d = BUSY;
      BUSY:      if (cnt_q == '0) state_d = RESPOND;
      RESPOND:   state_d = WAIT_DROP;
      WAIT_DROP: if (!bus.request) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Reset on the completing edge must abort: nothing reaches the array.
  assign fire   = (state_q == BUSY) && (cnt_q == '0) && !reset;
  assign arr_we = fire && we_q;
  assign arr_re = fire && !we_q;

  assign bus.valid = (state_q == RESPOND);
  assign bus.busy  = (state_q != IDLE);

  mem_line_array #(
    .LINEW (LINEW),
    .DEPTH (DEPTH)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .we    (arr_we),
    .widx  (idx_q),
    .wdata (wdata_q),
    .re    (arr_re),
    .ridx  (idx_q),
    .rdata (bus.rdata)
  );

`ifdef MEM_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (arr_re && rd_count != '1) rd_count <= rd_count + 32'd1;
      if (arr_we && wr_count != '1) wr_count <= wr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: two instances (LATENCY 4 and 1) share stimulus.
// Expected read lines are queued at drive time and popped on each valid.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int LINEW = MEM_LINEW;
  localparam int OFFW  = line_offw(LINEW);
  localparam int IDXW  = 10;
  localparam int LAT0  = 4;
  localparam int LAT1  = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             req;
  logic             w;
  logic [31:0]      a;
  logic [LINEW-1:0] d;

  mem_responder_if b0 ();
  mem_responder_if b1 ();

  assign b0.request = req;
  assign b0.we      = w;
  assign b0.addr    = a;
  assign b0.wdata   = d;
  assign b1.request = req;
  assign b1.we      = w;
  assign b1.addr    = a;
  assign b1.wdata   = d;

`ifdef MEM_STATS_EN
  logic [31:0] rc0, wc0, rc1, wc1;
`endif

  mem_responder #(.LATENCY(LAT0)) u0 (
    .clock (clk),
    .reset (rst),
    .bus   (b0)
`ifdef MEM_STATS_EN
    ,
    .rd_count (rc0),
    .wr_count (wc0)
`endif
  );

  mem_responder #(.LATENCY(LAT1)) u1 (
    .clock (clk),
    .reset (rst),
    .bus   (b1)
`ifdef MEM_STATS_EN
    ,
    .rd_count (rc1),
    .wr_count (wc1)
`endif
  );

  int checks = 0;
  int errors = 0;
  int nrd = 0;
  int nwr = 0;

  logic [LINEW-1:0] model [int];
  logic [LINEW-1:0] last_rd = '0;
  logic [LINEW-1:0] sb0 [$];
  logic [LINEW-1:0] sb1 [$];

  task automatic chk(input string tag,
                     input logic [LINEW-1:0] obs,
                     input logic [LINEW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic wr, input logic [31:0] adr,
                        input logic [LINEW-1:0] dat, input int hold);
    int idx, k0, k1, n0, n1, kmax;
    bit done;
    logic [LINEW-1:0] exp;
    @(negedge clk);
    req = 1'b1; w = wr; a = adr; d = dat;
    idx = int'(adr[OFFW +: IDXW]);
    if (wr) begin
      exp = last_rd;
      model[idx] = dat;
      nwr++;
    end else begin
      exp = model.exists(idx) ? model[idx] : '0;
      last_rd = exp;
      nrd++;
    end
    sb0.push_back(exp);
    sb1.push_back(exp);
    k0 = 0; k1 = 0; n0 = 0; n1 = 0; done = 0;
    for (int k = 1; k <= 300 && !done; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        a = $urandom;
        d = {16{$urandom}};
        w = ~wr;
      end
      if (b0.valid) begin
        n0++;
        if (k0 == 0) begin
          k0 = k;
          chk("rdata0", b0.rdata, sb0.pop_front());
        end
      end
      if (b1.valid) begin
        n1++;
        if (k1 == 0) begin
          k1 = k;
          chk("rdata1", b1.rdata, sb1.pop_front());
        end
      end
      kmax = (k0 > k1) ? k0 : k1;
      if (k0 != 0 && k1 != 0 && k >= kmax + hold) done = 1;
    end
    if (k0 == 0 && sb0.size() > 0) void'(sb0.pop_front());
    if (k1 == 0 && sb1.size() > 0) void'(sb1.pop_front());
    chk("lat0", LINEW'(k0), LINEW'(LAT0 + 1));
    chk("lat1", LINEW'(k1), LINEW'(LAT1 + 1));
    chk("busy_held", LINEW'({b0.busy, b1.busy}), LINEW'(2'b11));
    @(negedge clk);
    req = 1'b0;
    for (int j = 0; j < 3 && (b0.busy || b1.busy); j++) begin
      @(posedge clk); #1;
      n0 += int'(b0.valid);
      n1 += int'(b1.valid);
    end
    chk("idle", LINEW'({b0.busy, b1.busy}), LINEW'(2'b00));
    chk("pulses0", LINEW'(n0), LINEW'(1));
    chk("pulses1", LINEW'(n1), LINEW'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    int nv;
    logic [LINEW-1:0] p1;
    p1 = {8{64'h0123_4567_89AB_CDEF}};
    rst = 1'b1; req = 1'b0; w = 1'b0; a = '0; d = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", LINEW'({b0.valid, b1.valid}), '0);
    chk("rst_busy", LINEW'({b0.busy, b1.busy}), '0);
    chk("rst_rdata0", b0.rdata, '0);
    chk("rst_rdata1", b1.rdata, '0);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    repeat (10) begin
      @(posedge clk); #1;
      nv += int'(b0.valid) + int'(b1.valid) + int'(b0.busy);
    end
    chk("idle_quiet", LINEW'(nv), '0);

    access(1'b1, 32'(5 << OFFW), {16{32'hDEADBEEF}}, 0);
    access(1'b0, 32'(5 << OFFW), '0, 6);
    access(1'b1, 32'((7 << OFFW) | 32'h3C | 32'h0010_0000), p1, 1);

    @(negedge clk);
    req = 1'b1; w = 1'b1; a = 32'(7 << OFFW); d = {16{32'h0000_00A5}};
    @(posedge clk); #1;
    chk("abort_busy", LINEW'({b0.busy, b1.busy}), LINEW'(2'b11));
    @(negedge clk);
    rst = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    chk("abort_state", LINEW'({b0.valid, b1.valid, b0.busy, b1.busy}), '0);
    chk("abort_rdata", b0.rdata | b1.rdata, '0);
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
    nv = 0;
    repeat (6) begin
      @(posedge clk); #1;
      nv += int'(b0.valid) + int'(b1.valid);
    end
    chk("abort_novalid", LINEW'(nv), '0);

    access(1'b0, 32'(7 << OFFW), '0, 2);
    access(1'b0, 32'((9 << OFFW) | 32'h3F), '0, 0);

`ifdef MEM_STATS_EN
    chk("rd_count0", LINEW'(rc0), LINEW'(nrd));
    chk("wr_count0", LINEW'(wc0), LINEW'(nwr));
    chk("rd_count1", LINEW'(rc1), LINEW'(nrd));
    chk("wr_count1", LINEW'(wc1), LINEW'(nwr));
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
